// File: rtl/mem_access_sched.sv
// mem_access_sched: arbitrates the single memory port of the multicycle
// datapath between instruction fetch, data load/store and exception-vector
// reads. It drives the address-source mux select, the memory strobes, and
// walks each transaction through the fixed memory latency before pulsing
// the done of the requester it granted.
//
// Optional feature macro: MEM_SEQ_RR_EN
//   defined   -> data and fetch alternate round-robin when both are
//                pending (exception reads keep absolute priority)
//   undefined -> fixed priority exc > data > fetch
module mem_access_sched #(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic       data_we,
    input  logic       exc_req,
    output logic [2:0] addr_sel,
    output logic       mem_en,
    output logic       mem_wr,
    output logic       fetch_done,
    output logic       data_done,
    output logic       exc_done,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    // Grant codes double as the low two bits of the address mux select.
    typedef enum logic [1:0] {
        GNT_FETCH = 2'd0,
        GNT_DATA  = 2'd1,
        GNT_EXC   = 2'd2
    } grant_t;

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

    state_t           state;
    grant_t           grant;
    grant_t           next_grant;
    logic             any_req;
    logic [CNT_W-1:0] cnt;

`ifdef MEM_SEQ_RR_EN
    grant_t           last_grant;
`endif

    assign any_req = exc_req | data_req | fetch_req;

    // Pick the winner among the currently raised requests.
    always_comb begin
        next_grant = GNT_FETCH;
        if (exc_req) begin
            next_grant = GNT_EXC;
        end
`ifdef MEM_SEQ_RR_EN
        else if (data_req && fetch_req) begin
            next_grant = (last_grant == GNT_DATA) ? GNT_FETCH : GNT_DATA;
        end
`endif
        else if (data_req) begin
            next_grant = GNT_DATA;
        end else begin
            next_grant = GNT_FETCH;
        end
    end

    // Transaction sequencer; every output is registered so it can be seen
    // glitch-free by the memory and the control unit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= GNT_FETCH;
            cnt        <= '0;
            addr_sel   <= 3'b000;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            fetch_done <= 1'b0;
            data_done  <= 1'b0;
            exc_done   <= 1'b0;
            busy       <= 1'b0;
`ifdef MEM_SEQ_RR_EN
            last_grant <= GNT_FETCH;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        // mem_wr captures data_we at grant, so later changes
                        // of data_we cannot affect this transaction.
                        state    <= ISSUE;
                        grant    <= next_grant;
                        addr_sel <= {1'b0, next_grant};
                        mem_en   <= 1'b1;
                        mem_wr   <= (next_grant == GNT_DATA) && data_we;
                        busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    state  <= WAIT;
                    cnt    <= LAT_M1;
                    mem_en <= 1'b0;
                    mem_wr <= 1'b0;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= DONE;
                        fetch_done <= (grant == GNT_FETCH);
                        data_done  <= (grant == GNT_DATA);
                        exc_done   <= (grant == GNT_EXC);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    addr_sel   <= 3'b000;
                    fetch_done <= 1'b0;
                    data_done  <= 1'b0;
                    exc_done   <= 1'b0;
                    busy       <= 1'b0;
`ifdef MEM_SEQ_RR_EN
                    if (grant != GNT_EXC) begin
                        last_grant <= grant;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
